// File: rtl/sail_div_pkg.sv
// ============================================================================
// Module : sail_div_pkg
// Brief  : Shared op encodings, FSM states and constants for the sail divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sail_div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q       = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] DIV_OVF_DIVIDEND = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/sail_iter_divider_if.sv
// ============================================================================
// Module : sail_iter_divider_if
// Brief  : Start/done handshake and operand/result bus of the iterative divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sail_iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i,
    output busy_o, done_o, result_o
  );
endinterface

`default_nettype wire

// File: rtl/sail_div_step.sv
// ============================================================================
// Module : sail_div_step
// Brief  : One restoring shift-subtract iteration; purely combinational.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sail_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;

  // The sign bit of the widened difference is the trial-subtract borrow.
  always_comb begin
    w_shifted = {rem_i, quo_i[WIDTH-1]};
    w_diff    = w_shifted - {2'b00, divisor_i};
    w_borrow  = w_diff[WIDTH+1];
    if (w_borrow) begin
      rem_o = w_shifted[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = w_diff[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/sail_iter_divider.sv
// ============================================================================
// Module : sail_iter_divider
// Brief  : Multi-cycle RV32M DIV/DIVU/REM/REMU divider, one quotient bit/cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sail_iter_divider
  import sail_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  sail_iter_divider_if.slave bus
);

  localparam int                  CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]    c_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]    c_ZERO_Q = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]    c_OVF    = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic             w_signed_in;
  logic             w_neg_a;
  logic             w_neg_b;
  logic             w_signed_q;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  sail_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (w_step_rem),
    .quo_o     (w_step_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DIV_IDLE;
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Signed ops are those with op[0] clear (DIV, REM); magnitudes are loaded for them.
  always_comb begin
    w_signed_in = ~bus.op_i[0];
    w_neg_a     = w_signed_in & bus.dividend_i[WIDTH-1];
    w_neg_b     = w_signed_in & bus.divisor_i[WIDTH-1];
    w_signed_q  = ~op_q[0];
    w_quo_fix   = (w_signed_q & (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
    w_rem_fix   = (w_signed_q & sign_a_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    count_d  = count_q;
    result_d = result_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start_i) begin
          op_d     = bus.op_i;
          sign_a_d = bus.dividend_i[WIDTH-1];
          sign_b_d = bus.divisor_i[WIDTH-1];
          quo_d    = w_neg_a ? -bus.dividend_i : bus.dividend_i;
          dvs_d    = w_neg_b ? -bus.divisor_i : bus.divisor_i;
          rem_d    = '0;
          count_d  = '0;
          if (bus.divisor_i == '0) begin
            result_d = bus.op_i[1] ? bus.dividend_i : c_ZERO_Q;
            state_d  = DIV_DONE;
          end else if (w_signed_in && (bus.dividend_i == c_OVF) &&
                       (bus.divisor_i == {WIDTH{1'b1}})) begin
            result_d = bus.op_i[1] ? '0 : c_OVF;
            state_d  = DIV_DONE;
          end else begin
            state_d  = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d   = w_step_rem;
        quo_d   = w_step_quo;
        count_d = count_q + 1'b1;
        if (count_q == c_LAST) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        result_d = op_q[1] ? w_rem_fix : w_quo_fix;
        state_d  = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  assign bus.busy_o   = (state_q != DIV_IDLE);
  assign bus.done_o   = (state_q == DIV_DONE);
  assign bus.result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_sail_iter_divider.sv
// ============================================================================
// Module : tb_sail_iter_divider
// Brief  : Vector table + random ops against a queue scoreboard, plus corner sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sail_iter_divider;
  import sail_div_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          sp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          due;
    int          id;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sail_iter_divider_if #(.WIDTH(32)) bus ();

  sail_iter_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;
  sb_t  sbq[$];
  sb_t  mon_e;
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output side of the scoreboard: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.done_o === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h expected no done pulse", bus.result_o);
      end else begin
        mon_e = sbq.pop_front();
        check($sformatf("result[%0d]", mon_e.id), bus.result_o, mon_e.res);
        check($sformatf("done_cycle[%0d]", mon_e.id), 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0) return op[1] ? a : DIV_ZERO_Q;
    if (!op[0]) begin
      if (a == DIV_OVF_DIVIDEND && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : DIV_OVF_DIVIDEND;
      return op[1] ? 32'(sa % sbv) : 32'(sa / sbv);
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == DIV_OVF_DIVIDEND && b == 32'hFFFF_FFFF);
  endfunction

  // Called at a negedge; start is sampled by the next rising edge.
  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit sp, input bit push);
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    if (push) begin
      sbq.push_back('{res: exp, due: cyc + (sp ? 1 : 34), id: next_id});
      next_id++;
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy_o !== 1'b0; i++) @(negedge clk);
    if (bus.busy_o !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy %b expected 0", bus.busy_o);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit sp);
    wait_idle();
    do_start(op, a, b, exp, sp, 1'b1);
    wait_drain();
  endtask

  initial begin
    int          m;
    int          nbusy;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          sel;

    vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    vecs[5]  = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[6]  = '{DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[7]  = '{DIV_OP_REM,  32'h8000_0005,  32'd0,          32'h8000_0005,  1'b1};
    vecs[8]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[9]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[10] = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[11] = '{DIV_OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          1'b0};
    vecs[12] = '{DIV_OP_DIV,  32'd0,          32'd5,          32'd0,          1'b0};
    vecs[13] = '{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[14] = '{DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
    vecs[15] = '{DIV_OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
    vecs[16] = '{DIV_OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0};
    vecs[17] = '{DIV_OP_DIVU, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[18] = '{DIV_OP_DIV,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[19] = '{DIV_OP_REMU, 32'd12345,      32'd0,          32'd12345,      1'b1};

    reset          = 1'b1;
    bus.start_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(bus.busy_o),  32'd0);
    check("reset_done",   32'(bus.done_o),  32'd0);
    check("reset_result", bus.result_o,     32'd0);
    reset = 1'b0;
    @(negedge clk);

    // DIVU 100/7 with busy-window length measured
    do_start(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy_o === 1'b1) nbusy++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(nbusy), 32'd34);
    wait_drain();

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].sp);
    end

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        3:       begin ra = DIV_OVF_DIVIDEND; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, model(rop, ra, rb), is_special(rop, ra, rb));
    end

    // Reset in the middle of an operation: no done may ever follow.
    wait_idle();
    m = cyc;
    do_start(DIV_OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
    while (cyc < m + 10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy",   32'(bus.busy_o), 32'd0);
    check("midreset_done",   32'(bus.done_o), 32'd0);
    check("midreset_result", bus.result_o,    32'd0);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    run_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // Starts while busy (CALC and DONE) are ignored; the one right after DONE is taken.
    wait_idle();
    m = cyc;
    do_start(DIV_OP_DIVU, 32'd50, 32'd5, 32'd10, 1'b0, 1'b1);
    while (cyc < m + 5) @(negedge clk);
    do_start(DIV_OP_DIVU, 32'd8, 32'd2, 32'd0, 1'b0, 1'b0);
    while (cyc < m + 34) @(negedge clk);
    do_start(DIV_OP_DIVU, 32'd8, 32'd2, 32'd0, 1'b0, 1'b0);
    check("idle_at_cycle35", 32'(bus.busy_o), 32'd0);
    do_start(DIV_OP_DIVU, 32'd8, 32'd2, 32'd4, 1'b0, 1'b1);
    wait_drain();

    repeat (40) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
